// File: rtl/uart_dbg_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_dbg_cmd_bridge
// Purpose  : Host debug command decoder sitting between the UART byte
//            receiver/transmitter and the NES system memory bus. It parses
//            four host commands (halt, resume, write byte, read byte),
//            issues single-cycle bus strobes and returns read data as one
//            UART byte. It also owns cpu_halt, which stalls the CPU and
//            keeps the PPU off the bus while the host is using it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          system clock (25 MHz domain)
//   rst          asynchronous reset, active low
//   i_rx_valid   one-cycle strobe, i_rx_data holds a received byte
//   i_rx_data    received UART byte
//   o_tx_start   one-cycle request to UART TX
//   o_tx_data    byte to transmit, held stable while TX is busy
//   i_tx_active  UART TX busy
//   o_cpu_halt   1 = CPU halted, debug owns the bus
//   i_dbg_gnt    bus arbiter grant (CPU reached its halt boundary)
//   o_bus_addr   debug bus address
//   o_bus_wdata  debug write data
//   o_bus_wr     one-cycle write strobe
//   o_bus_rd     one-cycle read strobe
//   i_bus_rdata  read data, valid RD_LATENCY cycles after o_bus_rd
//   o_state_out  current FSM state encoding (7-seg debug display)
//   o_err_cnt    saturating count of timeouts and grant-less accesses
// ============================================================================
module uart_dbg_cmd_bridge #(
   parameter int RD_LATENCY     = 1,        // 1..7 cycles bus_rd -> bus_rdata
   parameter int TIMEOUT_CYCLES = 2500000,  // inter-byte idle limit
   parameter int TO_W           = 22        // timeout counter width
) (
   input  logic        clk,
   input  logic        rst,          // active low, asynchronous
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_data,
   output logic        o_tx_start,
   output logic [7:0]  o_tx_data,
   input  logic        i_tx_active,
   output logic        o_cpu_halt,
   input  logic        i_dbg_gnt,
   output logic [15:0] o_bus_addr,
   output logic [7:0]  o_bus_wdata,
   output logic        o_bus_wr,
   output logic        o_bus_rd,
   input  logic [7:0]  i_bus_rdata,
   output logic [3:0]  o_state_out,
   output logic [7:0]  o_err_cnt
);

   // Encodings are visible on the debug display, so they are fixed.
   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      GET_AH   = 4'd1,
      GET_AL   = 4'd2,
      GET_D    = 4'd3,
      WAIT_GNT = 4'd4,
      WR       = 4'd5,
      RD       = 4'd6,
      RD_WAIT  = 4'd7,
      TX_REQ   = 4'd8,
      TX_BUSY  = 4'd9
   } state_t;

   localparam logic [7:0]      c_CMD_HALT   = 8'h00;
   localparam logic [7:0]      c_CMD_RESUME = 8'h01;
   localparam logic [7:0]      c_CMD_WRITE  = 8'h02;
   localparam logic [7:0]      c_CMD_READ   = 8'h03;
   localparam logic [TO_W-1:0] c_TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]      c_LAT_LAST   = 3'(RD_LATENCY - 1);

   state_t          r_state;
   state_t          w_next;

   logic            r_halt;
   logic            r_is_wr;      // 1 = write command, 0 = read command
   logic [15:0]     r_addr;
   logic [7:0]      r_wdata;
   logic [7:0]      r_tx_data;
   logic [7:0]      r_err_cnt;
   logic [TO_W-1:0] r_to_cnt;
   logic [2:0]      r_lat_cnt;
   logic            r_tx_seen;    // TX busy observed since entering TX_BUSY

   logic            w_to_hit;
   logic            w_to_run;
   logic            w_err_inc;
   logic            w_halt_set;
   logic            w_halt_clr;
   logic            w_load_cmd;
   logic            w_load_ah;
   logic            w_load_al;
   logic            w_load_d;
   logic            w_capture;
   logic            w_bus_wr;
   logic            w_bus_rd;
   logic            w_tx_start;

   // Last idle cycle of the timeout window for the current state.
   assign w_to_hit = (r_to_cnt == c_TO_LAST);

   // The timeout counter only runs while waiting on the host or the arbiter.
   assign w_to_run = (r_state == GET_AH) || (r_state == GET_AL) ||
                     (r_state == GET_D)  || (r_state == WAIT_GNT);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and control decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_next     = r_state;
      w_err_inc  = 1'b0;
      w_halt_set = 1'b0;
      w_halt_clr = 1'b0;
      w_load_cmd = 1'b0;
      w_load_ah  = 1'b0;
      w_load_al  = 1'b0;
      w_load_d   = 1'b0;
      w_capture  = 1'b0;
      w_bus_wr   = 1'b0;
      w_bus_rd   = 1'b0;
      w_tx_start = 1'b0;

      case (r_state)
         IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  c_CMD_HALT:   w_halt_set = 1'b1;
                  c_CMD_RESUME: w_halt_clr = 1'b1;
                  c_CMD_WRITE,
                  c_CMD_READ: begin
                     w_load_cmd = 1'b1;
                     w_next     = GET_AH;
                  end
                  default: ;  // unknown opcodes are ignored
               endcase
            end
         end

         GET_AH: begin
            if (i_rx_valid) begin
               w_load_ah = 1'b1;
               w_next    = GET_AL;
            end else if (w_to_hit) begin
               w_err_inc = 1'b1;
               w_next    = IDLE;
            end
         end

         GET_AL: begin
            if (i_rx_valid) begin
               w_load_al = 1'b1;
               w_next    = r_is_wr ? GET_D : WAIT_GNT;
            end else if (w_to_hit) begin
               w_err_inc = 1'b1;
               w_next    = IDLE;
            end
         end

         GET_D: begin
            if (i_rx_valid) begin
               w_load_d = 1'b1;
               w_next   = WAIT_GNT;
            end else if (w_to_hit) begin
               w_err_inc = 1'b1;
               w_next    = IDLE;
            end
         end

         WAIT_GNT: begin
            if (!r_halt) begin
               // CPU not halted: the host asked for an ungated access. It is
               // still carried out, but flagged as an error.
               w_err_inc = 1'b1;
               w_next    = r_is_wr ? WR : RD;
            end else if (i_dbg_gnt) begin
               w_next = r_is_wr ? WR : RD;
            end else if (w_to_hit) begin
               w_err_inc = 1'b1;
               w_next    = IDLE;
            end
         end

         WR: begin
            w_bus_wr = 1'b1;
            w_next   = IDLE;
         end

         RD: begin
            // Exactly one read strobe: several PPU registers have read
            // side effects.
            w_bus_rd = 1'b1;
            w_next   = RD_WAIT;
         end

         RD_WAIT: begin
            if (r_lat_cnt == c_LAT_LAST) begin
               w_capture = 1'b1;
               w_next    = TX_REQ;
            end
         end

         TX_REQ: begin
            if (!i_tx_active) begin
               w_tx_start = 1'b1;
               w_next     = TX_BUSY;
            end
         end

         TX_BUSY: begin
            if (r_tx_seen && !i_tx_active) begin
               w_next = IDLE;
            end
         end

         default: w_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_halt    <= 1'b0;
         r_is_wr   <= 1'b0;
         r_addr    <= 16'h0000;
         r_wdata   <= 8'h00;
         r_tx_data <= 8'h00;
         r_err_cnt <= 8'h00;
         r_to_cnt  <= '0;
         r_lat_cnt <= 3'd0;
         r_tx_seen <= 1'b0;
      end else begin
         if (w_halt_set) begin
            r_halt <= 1'b1;
         end else if (w_halt_clr) begin
            r_halt <= 1'b0;
         end

         if (w_load_cmd) begin
            r_is_wr <= (i_rx_data == c_CMD_WRITE);
         end
         if (w_load_ah) begin
            r_addr[15:8] <= i_rx_data;
         end
         if (w_load_al) begin
            r_addr[7:0] <= i_rx_data;
         end
         if (w_load_d) begin
            r_wdata <= i_rx_data;
         end
         if (w_capture) begin
            r_tx_data <= i_bus_rdata;
         end

         if (w_err_inc && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end

         // Any state change (including every accepted header byte) restarts
         // the idle window.
         if (w_next != r_state) begin
            r_to_cnt <= '0;
         end else if (w_to_run) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end

         if (r_state == RD_WAIT) begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
         end else begin
            r_lat_cnt <= 3'd0;
         end

         // TX_BUSY must see the transmitter go busy before it can treat
         // tx_active=0 as "finished".
         if (r_state == TX_BUSY) begin
            r_tx_seen <= r_tx_seen | i_tx_active;
         end else begin
            r_tx_seen <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign o_tx_start  = w_tx_start;
   assign o_tx_data   = r_tx_data;
   assign o_cpu_halt  = r_halt;
   assign o_bus_addr  = r_addr;
   assign o_bus_wdata = r_wdata;
   assign o_bus_wr    = w_bus_wr;
   assign o_bus_rd    = w_bus_rd;
   assign o_state_out = r_state;
   assign o_err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/uart_dbg_cmd_bridge.md
Name: uart_dbg_cmd_bridge

Overview:
Debug command decoder between the UART byte receiver/transmitter and the system memory bus (CPU/PPU register space) of the NES top level. It parses the host byte protocol: halt CPU, resume CPU, write byte, read byte. It performs single-cycle bus strobes and returns read data as one UART byte. It also drives cpu_halt, which gates the CPU and holds the PPU off the bus while the host owns it.

Parameters:
RD_LATENCY, 1, cycles from bus_rd pulse to valid bus_rdata (1..7)
TIMEOUT_CYCLES, 2500000, idle cycles allowed between bytes of one command before abort (100 ms at 25 MHz)
TO_W, 22, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock (25 MHz domain)
rst  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
rx_data  in  8  received UART byte
tx_start  out  1  one-cycle request to UART TX
tx_data  out  8  byte to transmit, stable while tx_active
tx_active  in  1  UART TX busy
cpu_halt  out  1  1 = CPU halted, debug owns bus
dbg_gnt  in  1  bus arbiter grant (CPU reached halt boundary)
bus_addr  out  16  debug bus address
bus_wdata  out  8  debug write data
bus_wr  out  1  one-cycle write strobe
bus_rd  out  1  one-cycle read strobe
bus_rdata  in  8  read data
state_out  out  4  current FSM state encoding (7-seg debug)
err_cnt  out  8  saturating count of timeouts and grant-less accesses

Behaviour:
- Reset (async, rst=0): all outputs 0, cpu_halt=0, FSM=IDLE, counters 0. Asserting rst mid-command aborts immediately; no strobe emitted after release.
- Command bytes, decoded in IDLE only: 0x00 halt; 0x01 resume; 0x02 write (addr_hi, addr_lo, data); 0x03 read (addr_hi, addr_lo). Any other byte in IDLE is ignored and FSM stays IDLE.
- 0x00 sets cpu_halt=1 the cycle after rx_valid. 0x01 clears it. Both are idempotent.
- States: IDLE(0), GET_AH(1), GET_AL(2), GET_D(3), WAIT_GNT(4), WR(5), RD(6), RD_WAIT(7), TX_REQ(8), TX_BUSY(9).
- Write path: IDLE -0x02-> GET_AH -> GET_AL -> GET_D -> WAIT_GNT -> WR. Each transition happens on rx_valid. WR pulses bus_wr for exactly 1 cycle, then returns to IDLE. bus_addr/bus_wdata are stable from WAIT_GNT through WR.
- Read path: IDLE -0x03-> GET_AH -> GET_AL -> WAIT_GNT -> RD. RD pulses bus_rd for exactly 1 cycle; only one strobe per command, because $2007/$2002/$2004 reads have side effects. RD_WAIT counts RD_LATENCY cycles, then captures bus_rdata into tx_data. TX_REQ waits for tx_active=0, then pulses tx_start for 1 cycle. TX_BUSY waits for tx_active to rise, then fall, then returns to IDLE.
- WAIT_GNT: proceeds when cpu_halt=1 and dbg_gnt=1. If cpu_halt=0, the access is still performed after 1 cycle (bus ungated debug write) and err_cnt increments.
- Timeout: in GET_AH/GET_AL/GET_D the counter resets on every rx_valid. On reaching TIMEOUT_CYCLES the FSM goes to IDLE, err_cnt increments, and no strobe is emitted. WAIT_GNT uses the same counter; on expiry it aborts. An aborted read sends no byte.
- rx_valid arriving in WAIT_GNT/WR/RD/RD_WAIT/TX_* is dropped. The host waits for the response before the next command.
- err_cnt saturates at 0xFF.
- Command latency: final command byte rx_valid at cycle N; bus strobe at N+2 when grant is already high.

Test Plan:
- Reset then 0x00 -> cpu_halt=1 next cycle; 0x01 -> cpu_halt=0; 0x00,0x00 -> stays 1, err_cnt=0.
- Halted, dbg_gnt=1, send 02 20 06 3F -> single bus_wr pulse, bus_addr=0x2006, bus_wdata=0x3F; no tx_start.
- Halted, send 03 20 07 with bus_rdata=0xA5 after RD_LATENCY -> exactly one bus_rd, tx_start once with tx_data=0xA5, FSM back to IDLE after tx_active falls.
- Send 02 20 then stall TIMEOUT_CYCLES -> FSM IDLE, err_cnt=1, no bus_wr. Next full write executes normally.
- Garbage bytes 0x7F, 0xFF in IDLE -> ignored. Assert rst low during RD_WAIT -> all outputs 0, no tx_start after release.
- Back-to-back 256 write/read pairs to 0x2003/0x2004 with varying data -> every readback byte matches written data, err_cnt=0.
